// File: rtl/pipeline_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// PipelineRegs: shared types and constants for the pipeline controller.
//   ctrl_state_t : controller FSM state encoding
//   REG_ZERO     : architectural zero register index (never a hazard source)
//   ctrl_out_t   : bundle of register enables and bubble-insert flushes
//   OUT_*        : the fixed output actions the controller can select
// -----------------------------------------------------------------------------
package PipelineRegs;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2,
        REDIRECT   = 2'd3
    } ctrl_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic if_id_flush;
        logic id_ex_flush;
    } ctrl_out_t;

    // Bit order: pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush
    localparam ctrl_out_t OUT_RUN        = ctrl_out_t'(6'b111100);
    localparam ctrl_out_t OUT_MEM_WAIT   = ctrl_out_t'(6'b000000);
    localparam ctrl_out_t OUT_REDIRECT   = ctrl_out_t'(6'b111111);
    localparam ctrl_out_t OUT_REDIR_TAIL = ctrl_out_t'(6'b111110);
    localparam ctrl_out_t OUT_LOAD_USE   = ctrl_out_t'(6'b001101);
    localparam ctrl_out_t OUT_BUBBLE     = ctrl_out_t'(6'b011110);
    localparam ctrl_out_t OUT_RESET      = ctrl_out_t'(6'b000011);

endpackage

// File: rtl/pipeline_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_if: stage status and control signals between the pipeline
// datapath and its hazard/stall controller.
//   master : datapath side -- drives stage status, receives enables/flushes
//   slave  : controller side -- reads stage status, drives enables/flushes
// -----------------------------------------------------------------------------
interface pipeline_ctrl_if;

    logic       if_valid;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic       ex_valid;
    logic       ex_is_load;
    logic [4:0] ex_rd;
    logic       ex_redirect;
    logic       mem_req;
    logic       mem_ready;

    logic       pc_en;
    logic       if_id_en;
    logic       id_ex_en;
    logic       ex_mem_en;
    logic       if_id_flush;
    logic       id_ex_flush;

    modport master (
        output if_valid, id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output ex_valid, ex_is_load, ex_rd, ex_redirect, mem_req, mem_ready,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush
    );

    modport slave (
        input  if_valid, id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  ex_valid, ex_is_load, ex_rd, ex_redirect, mem_req, mem_ready,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush
    );

endinterface

// File: rtl/pipeline_ctrl_hazard_cmp.sv
// -----------------------------------------------------------------------------
// hazard_cmp: combinational load-use detector. Flags when the instruction in
// ID reads a register that the valid load in EX is about to write.
//   ex_valid, ex_is_load, ex_rd              : EX-stage producer
//   id_valid, id_rs1/2, id_uses_rs1/2        : ID-stage consumer
//   load_use                                 : hazard present this cycle
// -----------------------------------------------------------------------------
module hazard_cmp
    import PipelineRegs::*;
(
    input  logic       ex_valid,
    input  logic       ex_is_load,
    input  logic [4:0] ex_rd,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    output logic       load_use
);

    logic producer_s;
    logic rs1_hit_s;
    logic rs2_hit_s;

    // The zero register is hardwired, so a load targeting it can never hazard.
    assign producer_s = ex_valid & ex_is_load & (ex_rd != REG_ZERO) & id_valid;
    assign rs1_hit_s  = id_uses_rs1 & (id_rs1 == ex_rd);
    assign rs2_hit_s  = id_uses_rs2 & (id_rs2 == ex_rd);
    assign load_use   = producer_s & (rs1_hit_s | rs2_hit_s);

endmodule

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl: stall/flush controller for a 5-stage in-order pipeline.
// Resolves memory waits, taken redirects, load-use hazards and fetch bubbles
// (in that priority) into register enables and bubble-insert flushes.
//   clk       : rising-edge clock
//   reset     : asynchronous active-low reset
//   pif       : stage status in, enables/flushes out (slave modport)
//   stall_cnt : saturating count of cycles with pc_en low
// -----------------------------------------------------------------------------
module pipeline_ctrl
    import PipelineRegs::*;
#(
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_ctrl_if.slave         pif,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [STALL_CNT_W-1:0] CNT_MAX = {STALL_CNT_W{1'b1}};

    ctrl_state_t             state_r;
    ctrl_state_t             next_state_s;
    ctrl_out_t               act_s;
    ctrl_out_t               out_s;
    logic [STALL_CNT_W-1:0]  stall_cnt_r;
    logic                    load_use_s;
    logic                    mem_wait_s;
    logic                    redirect_s;

    hazard_cmp u_hazard_cmp (
        .ex_valid    (pif.ex_valid),
        .ex_is_load  (pif.ex_is_load),
        .ex_rd       (pif.ex_rd),
        .id_valid    (pif.id_valid),
        .id_rs1      (pif.id_rs1),
        .id_rs2      (pif.id_rs2),
        .id_uses_rs1 (pif.id_uses_rs1),
        .id_uses_rs2 (pif.id_uses_rs2),
        .load_use    (load_use_s)
    );

    assign mem_wait_s = pif.mem_req & ~pif.mem_ready;
    // A redirect from a bubble in EX is not a real branch outcome.
    assign redirect_s = pif.ex_valid & pif.ex_redirect;

    // Priority action select and next state. MEM_WAIT has no branch of its
    // own: once mem_ready rises it falls through to RUN behaviour in the
    // same cycle, so releasing a memory wait costs no extra cycle.
    always_comb begin
        act_s        = OUT_RUN;
        next_state_s = RUN;
        if (mem_wait_s) begin
            act_s        = OUT_MEM_WAIT;
            next_state_s = MEM_WAIT;
        end else if (redirect_s) begin
            act_s        = OUT_REDIRECT;
            next_state_s = REDIRECT;
        end else if (state_r == REDIRECT) begin
            // The fetch issued alongside the redirect is wrong-path; drop it.
            act_s        = OUT_REDIR_TAIL;
            next_state_s = RUN;
        end else if (load_use_s && (state_r != LOAD_STALL)) begin
            // After one stall cycle the load has moved to MEM and forwarding
            // covers the consumer, so the check is suppressed in LOAD_STALL.
            act_s        = OUT_LOAD_USE;
            next_state_s = LOAD_STALL;
        end else if (!pif.if_valid) begin
            act_s        = OUT_BUBBLE;
            next_state_s = RUN;
        end else begin
            act_s        = OUT_RUN;
            next_state_s = RUN;
        end
    end

    // Reset overrides the outputs immediately, independent of the clock.
    always_comb begin
        if (!reset) begin
            out_s = OUT_RESET;
        end else begin
            out_s = act_s;
        end
    end

    // FSM state and saturating stall counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= RUN;
            stall_cnt_r <= {STALL_CNT_W{1'b0}};
        end else begin
            state_r <= next_state_s;
            if (!act_s.pc_en && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign pif.pc_en       = out_s.pc_en;
    assign pif.if_id_en    = out_s.if_id_en;
    assign pif.id_ex_en    = out_s.id_ex_en;
    assign pif.ex_mem_en   = out_s.ex_mem_en;
    assign pif.if_id_flush = out_s.if_id_flush;
    assign pif.id_ex_flush = out_s.id_ex_flush;
    assign stall_cnt       = stall_cnt_r;

endmodule
